ysyx_22041752_mdu_ctrl: RTL and testbench

Sequencing controller for the shared multi-cycle multiplier and divider in the EX stage. It accepts a mul/div/rem request from EX and issues a one-cycle start pulse to the selected unit. It stalls EX until the unit returns, then holds the selected result until MEM accepts it. It kills in-flight operations on flush, and keeps a one-entry quotient/remainder cache so that a div/rem pair on identical operands takes a single pass through the divider.

---
 rtl/ysyx_22041752_mdu_ctrl.sv | 130 +++++++++++++
 tb/tb_ysyx_22041752_mdu_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mdu_ctrl.sv
// Sequencer for the shared multi-cycle multiplier/divider in EX: launches the
// selected unit, stalls EX until it returns, and caches the last div/rem pair.
module ysyx_22041752_mdu_ctrl #(
   parameter int WIDTH    = 64,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   input  logic             op_mul,
   input  logic             op_div,
   input  logic             op_rem,
   input  logic             div_u,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             ms_allowin,
   output logic             mul_start,
   output logic             div_start,
   output logic             unit_flush,
   input  logic             mul_out_valid,
   input  logic [WIDTH-1:0] mul_product,
   input  logic             div_out_valid,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic             md_stall,
   output logic             md_result_valid,
   output logic [WIDTH-1:0] md_result
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MUL_BUSY = 2'd1;
   localparam logic [1:0] S_DIV_BUSY = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_result;

   logic             r_cache_vld;
   logic [WIDTH-1:0] r_tag1;
   logic [WIDTH-1:0] r_tag2;
   logic             r_tag_u;
   logic [WIDTH-1:0] r_tag_q;
   logic [WIDTH-1:0] r_tag_r;

   logic w_is_md;
   logic w_is_div;
   logic w_hit;
   logic w_busy;
   logic w_launch;
   logic w_ld_hit;
   logic w_mul_done;
   logic w_div_done;

   assign w_is_md  = req_valid & (op_mul | op_div | op_rem);
   assign w_is_div = op_div | op_rem;
   assign w_hit    = CACHE_EN & r_cache_vld & w_is_div &
                     (src1 == r_tag1) & (src2 == r_tag2) & (div_u == r_tag_u);
   assign w_busy   = (r_state == S_MUL_BUSY) | (r_state == S_DIV_BUSY);

   // Gated by reset so nothing leaks to the units while reset is held.
   assign w_launch   = reset & (r_state == S_IDLE) & w_is_md & ~flush;
   assign w_ld_hit   = w_launch & w_hit;
   assign w_mul_done = (r_state == S_MUL_BUSY) & mul_out_valid & ~flush;
   assign w_div_done = (r_state == S_DIV_BUSY) & div_out_valid & ~flush;

   assign mul_start       = w_launch & op_mul;
   assign div_start       = w_launch & w_is_div & ~w_hit;
   assign unit_flush      = reset & flush & w_busy;
   assign md_stall        = reset & w_is_md & (r_state != S_DONE);
   assign md_result_valid = (r_state == S_DONE);
   assign md_result       = r_result;

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_md) begin
                  if (op_mul)     w_state_nxt = S_MUL_BUSY;
                  else if (w_hit) w_state_nxt = S_DONE;
                  else            w_state_nxt = S_DIV_BUSY;
               end
            end
            S_MUL_BUSY: if (mul_out_valid) w_state_nxt = S_DONE;
            S_DIV_BUSY: if (div_out_valid) w_state_nxt = S_DONE;
            S_DONE:     if (ms_allowin)    w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_hit)
            r_result <= op_rem ? r_tag_r : r_tag_q;
         else if (w_mul_done)
            r_result <= mul_product;
         else if (w_div_done)
            r_result <= op_rem ? div_remainder : div_quotient;
      end
   end

   // Only a completed divide refreshes the cache; flush leaves it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cache_vld <= 1'b0;
         r_tag1      <= '0;
         r_tag2      <= '0;
         r_tag_u     <= 1'b0;
         r_tag_q     <= '0;
         r_tag_r     <= '0;
      end else if (w_div_done) begin
         r_cache_vld <= 1'b1;
         r_tag1      <= src1;
         r_tag2      <= src2;
         r_tag_u     <= div_u;
         r_tag_q     <= div_quotient;
         r_tag_r     <= div_remainder;
      end
   end

endmodule

// File: tb/tb_ysyx_22041752_mdu_ctrl.sv
// Randomized self-checking bench for the MDU controller, with behavioural
// multiplier/divider stand-ins and a transaction-level reference model.
module tb_ysyx_22041752_mdu_ctrl;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         req_valid = 1'b0;
   logic         op_mul = 1'b0, op_div = 1'b0, op_rem = 1'b0, div_u = 1'b0;
   logic [W-1:0] src1 = '0, src2 = '0;
   logic         ms_allowin = 1'b1;
   logic         mul_start, div_start, unit_flush, md_stall, md_result_valid;
   logic         mul_out_valid, div_out_valid;
   logic [W-1:0] mul_product, div_quotient, div_remainder, md_result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22041752_mdu_ctrl #(.WIDTH(W), .CACHE_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
      .op_mul(op_mul), .op_div(op_div), .op_rem(op_rem), .div_u(div_u),
      .src1(src1), .src2(src2), .ms_allowin(ms_allowin),
      .mul_start(mul_start), .div_start(div_start), .unit_flush(unit_flush),
      .mul_out_valid(mul_out_valid), .mul_product(mul_product),
      .div_out_valid(div_out_valid), .div_quotient(div_quotient),
      .div_remainder(div_remainder), .md_stall(md_stall),
      .md_result_valid(md_result_valid), .md_result(md_result)
   );

   // RISC-V M-extension division semantics
   function automatic logic [W-1:0] ref_dr(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic u, input logic rem);
      logic signed [W-1:0] sa, sb, sq, sr;
      if (b == '0) return rem ? a : '1;
      if (u) return rem ? (a % b) : (a / b);
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return rem ? '0 : a;
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return rem ? sr : sq;
   endfunction

   // Unit stand-ins: respond exactly lat cycles after the start pulse,
   // and drive junk on the result buses whenever not valid.
   int           cyc = 0, m_fire = 0, d_fire = 0, mul_lat = 1, div_lat = 1;
   logic         m_busy = 1'b0, d_busy = 1'b0, inj_mul = 1'b0, inj_div = 1'b0;
   logic [W-1:0] m_p = '0, d_q = '0, d_r = '0, junk = '0;
   logic         m_now, d_now;

   assign m_now         = m_busy && (cyc == m_fire);
   assign d_now         = d_busy && (cyc == d_fire);
   assign mul_out_valid = m_now || inj_mul;
   assign div_out_valid = d_now || inj_div;
   assign mul_product   = m_now ? m_p : junk;
   assign div_quotient  = d_now ? d_q : ~junk;
   assign div_remainder = d_now ? d_r : {junk[W/2-1:0], junk[W-1:W/2]};

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0;
         d_busy <= 1'b0;
      end else begin
         cyc  <= cyc + 1;
         junk <= {$urandom, $urandom};
         if (unit_flush || m_now) m_busy <= 1'b0;
         if (unit_flush || d_now) d_busy <= 1'b0;
         if (mul_start) begin
            m_busy <= 1'b1; m_fire <= cyc + mul_lat; m_p <= src1 * src2;
         end
         if (div_start) begin
            d_busy <= 1'b1; d_fire <= cyc + div_lat;
            d_q <= ref_dr(src1, src2, div_u, 1'b0);
            d_r <= ref_dr(src1, src2, div_u, 1'b1);
         end
      end
   end

   // Model of the one-entry cache: operands of the last completed divide
   logic         cv = 1'b0, cu = 1'b0;
   logic [W-1:0] ca = '0, cb = '0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic u);
      req_valid = 1'b1;
      op_mul = (op == 0); op_div = (op == 1); op_rem = (op == 2);
      div_u = u; src1 = a; src2 = b;
   endtask

   task automatic clr_req();
      req_valid = 1'b0; op_mul = 1'b0; op_div = 1'b0; op_rem = 1'b0;
   endtask

   // op: 0 mul, 1 div, 2 rem; dcyc = cycles spent in DONE before MEM accepts
   task automatic do_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic u, input int lat, input int dcyc);
      logic         hit;
      logic [W-1:0] exp;
      int           n, stl, starts;
      hit = (op != 0) && cv && ca == a && cb == b && cu == u;
      exp = (op == 0) ? a * b : ref_dr(a, b, u, op == 2);
      mul_lat = lat; div_lat = lat;
      ms_allowin = 1'b0;
      set_req(op, a, b, u);
      #1;
      chk("launch_mul_start", W'(mul_start), W'(op == 0));
      chk("launch_div_start", W'(div_start), W'(op != 0 && !hit));
      n = 0; stl = 0; starts = 0;
      while (!md_result_valid && n < 64) begin
         stl += int'(md_stall);
         starts += int'(mul_start) + int'(div_start);
         step();
         n++;
      end
      chk("done_reached", W'(md_result_valid), W'(1));
      chk("stall_cycles", W'(stl), W'(hit ? 1 : lat + 1));
      chk("start_pulses", W'(starts), W'(hit ? 0 : 1));
      chk("result", md_result, exp);
      chk("stall_in_done", W'(md_stall), W'(0));
      for (int h = 1; h < dcyc; h++) begin
         step();
         chk("hold_valid", W'(md_result_valid), W'(1));
         chk("hold_result", md_result, exp);
         chk("hold_stall", W'(md_stall), W'(0));
      end
      ms_allowin = 1'b1;
      step();
      clr_req();
      #1;
      chk("left_done", W'(md_result_valid), W'(0));
      if (op != 0 && !hit) begin
         cv = 1'b1; ca = a; cb = b; cu = u;
      end
   endtask

   // Launch, then flush in cycle fcyc (fcyc=0 flushes the launch cycle itself)
   task automatic flush_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic u, input int lat, input int fcyc);
      mul_lat = lat; div_lat = lat;
      set_req(op, a, b, u);
      #1;
      for (int i = 0; i < fcyc; i++) step();
      flush = 1'b1;
      #1;
      chk("unit_flush", W'(unit_flush), W'(fcyc > 0));
      chk("no_start_on_flush", W'(mul_start | div_start), W'(0));
      step();
      flush = 1'b0;
      clr_req();
      #1;
      chk("unit_flush_one_cycle", W'(unit_flush), W'(0));
      chk("flushed_no_valid", W'(md_result_valid), W'(0));
      step();
      chk("flushed_still_idle", W'(md_result_valid), W'(0));
   endtask

   // Stale unit results arriving while idle must not produce a result
   task automatic idle_inject(input logic im, input logic id);
      inj_mul = im; inj_div = id;
      step();
      inj_mul = 1'b0; inj_div = 1'b0;
      #1;
      chk("stale_ignored", W'(md_result_valid), W'(0));
   endtask

   logic [W-1:0] pa [3];
   logic [W-1:0] pb [3];

   initial begin
      // Reset held with a live request and flush: everything stays quiet
      set_req(0, 64'd3, 64'd4, 1'b0);
      flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mul_start", W'(mul_start), W'(0));
      chk("rst_stall", W'(md_stall), W'(0));
      chk("rst_valid", W'(md_result_valid), W'(0));
      chk("rst_result", md_result, '0);
      reset = 1'b1; flush = 1'b0;
      clr_req();
      step();

      do_op(0, 64'd7, 64'd6, 1'b0, 3, 1);
      do_op(1, 64'd100, 64'd7, 1'b0, 4, 1);
      do_op(2, 64'd100, 64'd7, 1'b0, 4, 1);     // cache hit
      do_op(2, 64'd100, 64'd7, 1'b1, 2, 1);     // tag_u differs: miss
      do_op(0, 64'hffff_ffff_ffff_fff9, 64'd5, 1'b0, 2, 4);
      do_op(1, -64'sd100, 64'd7, 1'b0, 1, 2);

      flush_op(1, 64'd200, 64'd9, 1'b0, 6, 2);
      idle_inject(1'b0, 1'b1);
      do_op(2, 64'hffff_ffff_ffff_ff9c, 64'd7, 1'b0, 3, 1);  // still cached
      flush_op(1, 64'd300, 64'd11, 1'b0, 3, 3);              // flush meets out_valid
      do_op(1, 64'd300, 64'd11, 1'b0, 2, 1);                 // so this misses
      flush_op(0, 64'd5, 64'd5, 1'b0, 2, 0);
      flush_op(0, 64'd8, 64'd9, 1'b0, 4, 2);
      idle_inject(1'b1, 1'b1);

      for (int i = 0; i < 3; i++) begin
         pa[i] = {$urandom, $urandom};
         pb[i] = (i == 0) ? W'($urandom_range(1, 1000)) : {$urandom, $urandom};
      end
      pb[2] = '0;
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 2);
         do_op($urandom_range(0, 2), pa[k], pb[k], 1'($urandom_range(0, 1)),
               $urandom_range(1, 5), $urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0)
            idle_inject(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a multiply, then the cached pair must miss
      mul_lat = 10;
      set_req(0, 64'd5, 64'd9, 1'b0);
      #1;
      step(); step();
      flush = 1'b1; reset = 1'b0;
      #1;
      chk("midrst_mul_start", W'(mul_start), W'(0));
      chk("midrst_div_start", W'(div_start), W'(0));
      chk("midrst_unit_flush", W'(unit_flush), W'(0));
      chk("midrst_stall", W'(md_stall), W'(0));
      chk("midrst_valid", W'(md_result_valid), W'(0));
      chk("midrst_result", md_result, '0);
      step();
      reset = 1'b1; flush = 1'b0;
      clr_req();
      cv = 1'b0;
      step();
      do_op(2, ca, cb, cu, 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
